// File: rtl/alarm_controller_pkg.sv
// Shared encodings for the alarm controller: FSM states, digit indices and BCD limits.
// Also holds the wrap-around BCD increment used by the digit setter.
package alarm_controller_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_RINGING = 2'd2,
      ST_SNOOZE  = 2'd3
   } alarm_state_e;

   localparam logic [1:0] DIG_HR1  = 2'd0;
   localparam logic [1:0] DIG_HR0  = 2'd1;
   localparam logic [1:0] DIG_MIN1 = 2'd2;
   localparam logic [1:0] DIG_MIN0 = 2'd3;

   localparam logic [3:0] LIM_HR1     = 4'd2;
   localparam logic [3:0] LIM_HR0_20H = 4'd3;
   localparam logic [3:0] LIM_MIN1    = 4'd5;
   localparam logic [3:0] LIM_DEC     = 4'd9;

   // '>=' rather than '==' so an out-of-range digit still recovers to 0.
   function automatic logic [3:0] bcd_inc(input logic [3:0] v, input logic [3:0] lim);
      return (v >= lim) ? 4'd0 : v + 4'd1;
   endfunction

endpackage

// File: rtl/alarm_controller_digit_setter.sv
// Alarm-time registers (HH:MM BCD) and the digit cursor, edited with two one-pulse buttons.
// Hours are kept legal for a 24 h clock: hr0 is clamped whenever hr1 becomes 2.
module alarm_digit_setter
   import alarm_controller_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       setting_i,
   input  logic       pb_left_pu_i,
   input  logic       pb_right_pu_i,
   output logic [3:0] hr1_o,
   output logic [3:0] hr0_o,
   output logic [3:0] min1_o,
   output logic [3:0] min0_o,
   output logic [1:0] digit_sel_o
);

   logic [3:0] hr1_q, hr1_d, hr0_q, hr0_d, min1_q, min1_d, min0_q, min0_d;
   logic [1:0] digit_sel_q, digit_sel_d;

   always_comb begin
      hr1_d       = hr1_q;
      hr0_d       = hr0_q;
      min1_d      = min1_q;
      min0_d      = min0_q;
      digit_sel_d = digit_sel_q;
      if (setting_i) begin
         // The increment targets the cursor position before any simultaneous advance.
         if (pb_right_pu_i) begin
            case (digit_sel_q)
               DIG_HR1: begin
                  hr1_d = bcd_inc(hr1_q, LIM_HR1);
                  if (hr1_d == LIM_HR1 && hr0_q > LIM_HR0_20H)
                     hr0_d = LIM_HR0_20H;
               end
               DIG_HR0:  hr0_d  = bcd_inc(hr0_q, (hr1_q == LIM_HR1) ? LIM_HR0_20H : LIM_DEC);
               DIG_MIN1: min1_d = bcd_inc(min1_q, LIM_MIN1);
               DIG_MIN0: min0_d = bcd_inc(min0_q, LIM_DEC);
               default: ;
            endcase
         end
         if (pb_left_pu_i)
            digit_sel_d = digit_sel_q + 2'd1;
      end else begin
         digit_sel_d = DIG_HR1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         hr1_q       <= 4'd0;
         hr0_q       <= 4'd0;
         min1_q      <= 4'd0;
         min0_q      <= 4'd0;
         digit_sel_q <= DIG_HR1;
      end else begin
         hr1_q       <= hr1_d;
         hr0_q       <= hr0_d;
         min1_q      <= min1_d;
         min0_q      <= min0_d;
         digit_sel_q <= digit_sel_d;
      end
   end

   assign hr1_o       = hr1_q;
   assign hr0_o       = hr0_q;
   assign min1_o      = min1_q;
   assign min0_o      = min0_q;
   assign digit_sel_o = digit_sel_q;

endmodule

// File: rtl/alarm_controller.sv
// Alarm controller: compares the running BCD clock with the stored alarm time and
// runs the ring/snooze state machine that drives the buzzer enable.
module alarm_controller
   import alarm_controller_pkg::*;
#(
   parameter logic [7:0] RING_SECONDS   = 8'd60,
   parameter logic [7:0] SNOOZE_SECONDS = 8'd180
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sec_tick,
   input  logic       alarm_setting_mode,
   input  logic       alarm_en,
   input  logic       pb_left_pu,
   input  logic       pb_right_pu,
   input  logic       snooze_pu,
   input  logic [3:0] hr1_clock,
   input  logic [3:0] hr0_clock,
   input  logic [3:0] min1_clock,
   input  logic [3:0] min0_clock,
   output logic [3:0] alarm_hr1,
   output logic [3:0] alarm_hr0,
   output logic [3:0] alarm_min1,
   output logic [3:0] alarm_min0,
   output logic [1:0] digit_sel,
   output logic       ringing,
   output logic       buzz,
   output logic [1:0] alarm_state
);

   alarm_state_e state_q, state_d;
   logic [7:0]   cnt_q, cnt_d, cnt_inc;
   logic         blink_q, blink_d;
   logic         match, match_q, match_rise;
   logic         ringing_q, buzz_q;

   alarm_digit_setter u_setter (
      .clk           (clk),
      .reset         (reset),
      .setting_i     (alarm_setting_mode),
      .pb_left_pu_i  (pb_left_pu),
      .pb_right_pu_i (pb_right_pu),
      .hr1_o         (alarm_hr1),
      .hr0_o         (alarm_hr0),
      .min1_o        (alarm_min1),
      .min0_o        (alarm_min0),
      .digit_sel_o   (digit_sel)
   );

   assign match      = {hr1_clock, hr0_clock, min1_clock, min0_clock} ==
                       {alarm_hr1, alarm_hr0, alarm_min1, alarm_min0};
   assign match_rise = match & ~match_q;
   assign cnt_inc    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      blink_d = blink_q;
      if (alarm_setting_mode || !alarm_en) begin
         state_d = ST_IDLE;
         cnt_d   = 8'd0;
         blink_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_ARMED;
               cnt_d   = 8'd0;
               blink_d = 1'b0;
            end
            ST_ARMED: begin
               if (match_rise) begin
                  state_d = ST_RINGING;
                  cnt_d   = 8'd0;
                  blink_d = 1'b0;
               end
            end
            ST_RINGING: begin
               if (snooze_pu) begin
                  state_d = ST_SNOOZE;
                  cnt_d   = 8'd0;
                  blink_d = 1'b0;
               end else if (sec_tick) begin
                  cnt_d   = cnt_inc;
                  blink_d = ~blink_q;
                  if (cnt_inc == RING_SECONDS) begin
                     state_d = ST_ARMED;
                     cnt_d   = 8'd0;
                     blink_d = 1'b0;
                  end
               end
            end
            ST_SNOOZE: begin
               if (sec_tick) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == SNOOZE_SECONDS) begin
                     state_d = ST_RINGING;
                     cnt_d   = 8'd0;
                     blink_d = 1'b0;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 8'd0;
         blink_q   <= 1'b0;
         match_q   <= 1'b0;
         ringing_q <= 1'b0;
         buzz_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         blink_q   <= blink_d;
         match_q   <= match;
         ringing_q <= (state_d == ST_RINGING);
         buzz_q    <= (state_d == ST_RINGING) & blink_d;
      end
   end

   assign ringing     = ringing_q;
   assign buzz        = buzz_q;
   assign alarm_state = state_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller: stimulus pushes hand-computed expectations into a
// scoreboard queue and a negedge monitor pops and compares them against the DUT outputs.
module tb_alarm_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic       sec_tick, alarm_setting_mode, alarm_en;
   logic       pb_left_pu, pb_right_pu, snooze_pu;
   logic [3:0] hr1_clock, hr0_clock, min1_clock, min0_clock;
   logic [3:0] alarm_hr1, alarm_hr0, alarm_min1, alarm_min0;
   logic [1:0] digit_sel, alarm_state;
   logic       ringing, buzz;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      string       name;
      logic [21:0] v;
   } exp_t;
   exp_t sb_q[$];

   alarm_controller dut (
      .clk                (clk),
      .reset              (reset),
      .sec_tick           (sec_tick),
      .alarm_setting_mode (alarm_setting_mode),
      .alarm_en           (alarm_en),
      .pb_left_pu         (pb_left_pu),
      .pb_right_pu        (pb_right_pu),
      .snooze_pu          (snooze_pu),
      .hr1_clock          (hr1_clock),
      .hr0_clock          (hr0_clock),
      .min1_clock         (min1_clock),
      .min0_clock         (min0_clock),
      .alarm_hr1          (alarm_hr1),
      .alarm_hr0          (alarm_hr0),
      .alarm_min1         (alarm_min1),
      .alarm_min0         (alarm_min0),
      .digit_sel          (digit_sel),
      .ringing            (ringing),
      .buzz               (buzz),
      .alarm_state        (alarm_state)
   );

   always #5 clk = ~clk;

   // One clock edge with the given one-pulse inputs asserted, then the pulses drop.
   task automatic step(input logic l, input logic r, input logic s, input logic t);
      pb_left_pu  = l;
      pb_right_pu = r;
      snooze_pu   = s;
      sec_tick    = t;
      @(posedge clk);
      #1;
      pb_left_pu  = 1'b0;
      pb_right_pu = 1'b0;
      snooze_pu   = 1'b0;
      sec_tick    = 1'b0;
   endtask

   task automatic set_clock(input logic [15:0] t);
      {hr1_clock, hr0_clock, min1_clock, min0_clock} = t;
   endtask

   // Expected outputs: alarm HHMM, digit_sel, state, buzz; ringing follows from state==2.
   task automatic chk(input string nm, input logic [15:0] a, input logic [1:0] d,
                      input logic [1:0] st, input logic bz);
      exp_t e;
      e.name = nm;
      e.v    = {a, d, st, (st == 2'd2), bz};
      sb_q.push_back(e);
   endtask

   always @(negedge clk) begin
      while (sb_q.size() > 0) begin
         exp_t e;
         logic [21:0] got;
         e   = sb_q.pop_front();
         got = {alarm_hr1, alarm_hr0, alarm_min1, alarm_min0, digit_sel, alarm_state, ringing, buzz};
         n_checks++;
         if (got !== e.v) begin
            n_fail++;
            $display("FAIL %s: got alarm=%h sel=%0d state=%0d ring=%b buzz=%b, expected alarm=%h sel=%0d state=%0d ring=%b buzz=%b",
                     e.name, got[21:6], got[5:4], got[3:2], got[1], got[0],
                     e.v[21:6], e.v[5:4], e.v[3:2], e.v[1], e.v[0]);
         end else begin
            $display("ok   %s: alarm=%h sel=%0d state=%0d ring=%b buzz=%b",
                     e.name, got[21:6], got[5:4], got[3:2], got[1], got[0]);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; alarm_setting_mode = 1'b0; alarm_en = 1'b0;
      pb_left_pu = 1'b0; pb_right_pu = 1'b0; snooze_pu = 1'b0; sec_tick = 1'b0;
      set_clock(16'h0000);

      // Reset
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("reset", 16'h0000, 2'd0, 2'd0, 1'b0);
      reset = 1'b1;

      // Setting: hr1 wraps 2->0
      alarm_setting_mode = 1'b1;
      step(0, 0, 0, 0);
      step(0, 1, 0, 0); chk("hr1_inc1", 16'h1000, 2'd0, 2'd0, 1'b0);
      step(0, 1, 0, 0); chk("hr1_inc2", 16'h2000, 2'd0, 2'd0, 1'b0);
      step(0, 1, 0, 0); chk("hr1_wrap", 16'h0000, 2'd0, 2'd0, 1'b0);

      // Set 19:00, then hr1 -> 2 clamps hr0 to 3
      step(0, 1, 0, 0);
      step(1, 0, 0, 0); chk("left_to_hr0", 16'h1000, 2'd1, 2'd0, 1'b0);
      for (int i = 0; i < 9; i++) step(0, 1, 0, 0);
      chk("set_19", 16'h1900, 2'd1, 2'd0, 1'b0);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
      chk("sel_wrap", 16'h1900, 2'd0, 2'd0, 1'b0);
      step(0, 1, 0, 0); chk("clamp_23", 16'h2300, 2'd0, 2'd0, 1'b0);

      // Left x4 returns to the same digit
      step(1, 0, 0, 0); chk("left_1", 16'h2300, 2'd1, 2'd0, 1'b0);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
      chk("left_x4", 16'h2300, 2'd0, 2'd0, 1'b0);

      // hr0 wraps at 3 while hr1==2
      step(1, 0, 0, 0);
      step(0, 1, 0, 0); chk("hr0_wrap_20h", 16'h2000, 2'd1, 2'd0, 1'b0);

      // Build 07:30: hr1 2->0, hr0 0->7, min1 0->3 (last via simultaneous left+right)
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
      step(0, 1, 0, 0); chk("hr1_20_wrap", 16'h0000, 2'd0, 2'd0, 1'b0);
      step(1, 0, 0, 0);
      for (int i = 0; i < 7; i++) step(0, 1, 0, 0);
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      step(1, 1, 0, 0); chk("both_buttons", 16'h0730, 2'd3, 2'd0, 1'b0);

      // Leave setting: digit_sel returns to 0, buttons ignored
      alarm_setting_mode = 1'b0;
      step(0, 0, 0, 0); chk("leave_setting", 16'h0730, 2'd0, 2'd0, 1'b0);
      step(0, 1, 0, 0); chk("btn_ignored", 16'h0730, 2'd0, 2'd0, 1'b0);

      // Fire at 07:30
      set_clock(16'h0729);
      alarm_en = 1'b1;
      step(0, 0, 0, 0); chk("armed", 16'h0730, 2'd0, 2'd1, 1'b0);
      set_clock(16'h0730);
      step(0, 0, 0, 0); chk("fire", 16'h0730, 2'd0, 2'd2, 1'b0);
      step(0, 0, 0, 1); chk("tick1_buzz", 16'h0730, 2'd0, 2'd2, 1'b1);
      step(0, 0, 0, 0);
      step(0, 0, 0, 1); chk("tick2_buzz", 16'h0730, 2'd0, 2'd2, 1'b0);
      for (int i = 2; i < 59; i++) begin
         step(0, 0, 0, 0);
         step(0, 0, 0, 1);
      end
      chk("tick59_ringing", 16'h0730, 2'd0, 2'd2, 1'b1);
      step(0, 0, 0, 0);
      step(0, 0, 0, 1); chk("tick60_stop", 16'h0730, 2'd0, 2'd1, 1'b0);
      repeat (3) step(0, 0, 0, 0);
      chk("no_refire", 16'h0730, 2'd0, 2'd1, 1'b0);

      // Snooze: fire again, snooze together with sec_tick
      set_clock(16'h0731);
      step(0, 0, 0, 0);
      set_clock(16'h0730);
      step(0, 0, 0, 0); chk("refire", 16'h0730, 2'd0, 2'd2, 1'b0);
      step(0, 0, 0, 1); chk("refire_buzz", 16'h0730, 2'd0, 2'd2, 1'b1);
      step(0, 0, 1, 1); chk("snooze", 16'h0730, 2'd0, 2'd3, 1'b0);
      step(0, 0, 1, 0); chk("snooze_ignored", 16'h0730, 2'd0, 2'd3, 1'b0);
      for (int i = 0; i < 179; i++) step(0, 0, 0, 1);
      chk("snooze_179", 16'h0730, 2'd0, 2'd3, 1'b0);
      step(0, 0, 0, 1); chk("snooze_180", 16'h0730, 2'd0, 2'd2, 1'b0);
      step(0, 0, 0, 1); chk("resume_buzz", 16'h0730, 2'd0, 2'd2, 1'b1);

      // Disarm during SNOOZE
      step(0, 0, 1, 0); chk("snooze2", 16'h0730, 2'd0, 2'd3, 1'b0);
      alarm_en = 1'b0;
      step(0, 0, 0, 0); chk("disarm", 16'h0730, 2'd0, 2'd0, 1'b0);

      // Re-arm inside the matching minute: no ring
      alarm_en = 1'b1;
      step(0, 0, 0, 0); chk("rearm", 16'h0730, 2'd0, 2'd1, 1'b0);
      step(0, 0, 0, 0); chk("rearm_quiet", 16'h0730, 2'd0, 2'd1, 1'b0);

      // Setting mode while RINGING -> IDLE
      set_clock(16'h0731);
      step(0, 0, 0, 0);
      set_clock(16'h0730);
      step(0, 0, 0, 0); chk("fire3", 16'h0730, 2'd0, 2'd2, 1'b0);
      alarm_setting_mode = 1'b1;
      step(0, 0, 0, 0); chk("setting_kills_ring", 16'h0730, 2'd0, 2'd0, 1'b0);

      // Program 12:45, then reset mid-ring
      step(0, 1, 0, 0);
      step(1, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      step(1, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
      chk("set_1245", 16'h1245, 2'd3, 2'd0, 1'b0);
      alarm_setting_mode = 1'b0;
      step(0, 0, 0, 0); chk("arm_1245", 16'h1245, 2'd0, 2'd1, 1'b0);
      set_clock(16'h1245);
      step(0, 0, 0, 0); chk("fire_1245", 16'h1245, 2'd0, 2'd2, 1'b0);
      step(0, 0, 0, 1); chk("buzz_1245", 16'h1245, 2'd0, 2'd2, 1'b1);
      reset = 1'b0;
      step(0, 0, 0, 0); chk("reset_mid_ring", 16'h0000, 2'd0, 2'd0, 1'b0);
      reset = 1'b1;

      repeat (3) @(posedge clk);
      if (sb_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alarm_controller.md
Name: alarm_controller

Overview:
- Consumer end of the electronic clock's hr1_clock/hr0_clock/min1_clock/min0_clock time outputs.
- Holds a user-settable BCD alarm time (HH:MM, 24 h) and compares it against the running clock time.
- Drives a ring/snooze state machine that produces a buzzer/LED enable.
- Sits beside the electronic clock in the lab top level and shares its debounced one-pulse push buttons.

Parameters:
- RING_SECONDS, 60, seconds a ring lasts before auto-stop (8-bit counter)
- SNOOZE_SECONDS, 180, seconds of silence after a snooze request (8-bit counter)

Ports:
- clk  in  1  system clock (same clock as the electronic clock's counters)
- reset  in  1  synchronous, active-low reset
- sec_tick  in  1  one-cycle pulse per second
- alarm_setting_mode  in  1  1 = alarm-time setting mode
- alarm_en  in  1  alarm armed switch
- pb_left_pu  in  1  one-pulse: advance the selected digit
- pb_right_pu  in  1  one-pulse: increment the selected digit
- snooze_pu  in  1  one-pulse snooze request
- hr1_clock, hr0_clock, min1_clock, min0_clock  in  4 each  current BCD time
- alarm_hr1, alarm_hr0, alarm_min1, alarm_min0  out  4 each  stored alarm time
- digit_sel  out  2  selected digit: 0=hr1, 1=hr0, 2=min1, 3=min0
- ringing  out  1  high in RINGING
- buzz  out  1  ringing AND blink bit
- alarm_state  out  2  IDLE=0, ARMED=1, RINGING=2, SNOOZE=3

Behaviour:
- Reset (reset==0 at a clk edge): alarm time 00:00, digit_sel=0, state IDLE, sec counter 0, blink 0, match_q 0. So ringing=0, buzz=0, alarm_state=0.
- All outputs are registered. Everything below takes effect on the clk edge after the input condition.
- Setting mode (alarm_setting_mode==1):
  - pb_left_pu: digit_sel increments and wraps 3->0.
  - pb_right_pu: the selected digit increments and wraps to 0 past its limit. Limits: hr1 0..2; hr0 0..9, or 0..3 when hr1==2; min1 0..5; min0 0..9.
  - If hr1 becomes 2 while hr0>3, hr0 is forced to 3 in the same edge.
  - If both buttons pulse in the same cycle, the increment applies to the old digit_sel and then digit_sel advances.
- Outside setting mode: buttons are ignored, and digit_sel returns to 0 on the first cycle after setting mode is left.
- Match detection:
  - match = (clock HH:MM == alarm HH:MM). match_q holds the registered match.
  - match_rise = match AND NOT match_q, so an alarm fires once per minute, never again within the matching minute.
- FSM: any state goes to IDLE when alarm_setting_mode==1 or alarm_en==0 (highest priority).
  - IDLE: go to ARMED when alarm_en==1 and not setting. match_q is still updated, so arming during the matching minute does not fire.
  - ARMED: on match_rise go to RINGING, with sec counter=0 and blink=0.
  - RINGING: each sec_tick increments the counter and toggles blink. When the counter reaches RING_SECONDS on a tick, go to ARMED.
  - RINGING + snooze_pu: go to SNOOZE with counter=0. Snooze wins over a simultaneous sec_tick or timeout.
  - SNOOZE: each sec_tick increments the counter. When it reaches SNOOZE_SECONDS, go to RINGING with counter=0 and blink=0. snooze_pu in SNOOZE is ignored.
  - The counter saturates at 255. It is cleared on every state entry.
- Alarm-time edits in ARMED are impossible, because setting mode forces IDLE first.
- Reset mid-ring returns everything to reset values at once.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE/ARMED/RINGING/SNOOZE)
  - digit index constants (0..3)
  - BCD limit constants (2, 3, 5, 9)
- One natural sub-module, alarm_digit_setter: the four alarm BCD registers, digit_sel and the limit/clamp logic.
- The FSM, counter and match logic stay in alarm_controller.

Test Plan:
- Reset: hold reset=0 two cycles -> alarm 00:00, digit_sel=0, alarm_state=0, buzz=0.
- Setting:
  - From 00:00, pulse right ×3 on hr1 -> hr1 wraps to 0.
  - Set 19, then right on hr1 -> 29 clamps to 23.
  - Left ×4 -> digit_sel back to 0.
- Fire: set alarm 07:30, alarm_en=1, then present clock 07:29 -> 07:30 -> alarm_state=2 next cycle and ringing=1. buzz toggles per sec_tick. After 60 ticks, alarm_state=1, and there is no re-fire while the clock stays at 07:30.
- Snooze: while ringing, pulse snooze_pu in the same cycle as sec_tick -> alarm_state=3, buzz=0. After 180 ticks, alarm_state=2.
- Disarm/priority:
  - alarm_en=0 during SNOOZE -> IDLE next cycle.
  - alarm_setting_mode=1 while RINGING -> IDLE, ringing=0.
  - Re-arming during a matching minute does not ring.
- Reset mid-operation: reset=0 during RINGING with alarm 12:45 -> alarm 00:00, IDLE, buzz=0 next edge.
